// File: rtl/ox_ctrl_pkg.sv
// Shared types and constants for the O/X classifier training sequencer.
package ox_ctrl_pkg;

    localparam int unsigned PAT_W       = 16;
    localparam int unsigned SAMPLE_W    = 17;
    localparam int unsigned SETTLE_DEF  = 3;
    localparam int unsigned UPD_LAT_DEF = 2;

    // One stored training sample: {label, pattern}
    typedef struct packed {
        logic             label;
        logic [PAT_W-1:0] pat;
    } sample_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_APPLY     = 4'd1,
        ST_EVAL      = 4'd2,
        ST_LEARN     = 4'd3,
        ST_HOLD      = 4'd4,
        ST_NEXT      = 4'd5,
        ST_EPOCH_END = 4'd6,
        ST_DONE      = 4'd7,
        ST_INFER     = 4'd8
    } state_t;

endpackage

// File: rtl/ox_sample_mem.sv
// Training sample register file: synchronous write, combinational read, cleared by reset.
module ox_sample_mem
    import ox_ctrl_pkg::*;
#(
    parameter int unsigned NSAMP = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data_c
);

    sample_t mem [NSAMP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSAMP); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < NSAMP)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = (32'(rd_addr) < NSAMP) ? mem[rd_addr] : '0;

endmodule

// File: rtl/ox_train_ctrl.sv
// Epoch-based training sequencer for the O/X classifier, sharing it with one
// inference requester between runs.
module ox_train_ctrl
    import ox_ctrl_pkg::*;
#(
    parameter int unsigned NSAMP   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned SETTLE  = SETTLE_DEF,
    parameter int unsigned UPD_LAT = UPD_LAT_DEF,
    parameter int unsigned EPW     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [EPW-1:0]   cfg_max_epoch,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PAT_W-1:0] wr_x,
    input  logic             wr_label,
    input  logic             inf_req,
    input  logic [PAT_W-1:0] inf_x,
    output logic             inf_ack,
    output logic             inf_y,
    output logic [PAT_W-1:0] mlp_x,
    output logic             mlp_is_O,
    output logic             mlp_learn,
    input  logic             mlp_y,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [EPW-1:0]   epoch_cnt,
    output logic [AW:0]      err_cnt
);

    localparam int unsigned CMAX = (SETTLE > UPD_LAT) ? SETTLE : UPD_LAT;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned EW   = AW + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(UPD_LAT - 1);
    localparam logic [AW-1:0] IDX_LAST    = AW'(NSAMP - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    idx, idx_nxt, rd_addr;
    logic             from_done, from_done_nxt;
    sample_t          rd_data;
    sample_t          wr_data;

    logic [PAT_W-1:0] x_nxt;
    logic             is_o_nxt, learn_nxt, busy_nxt, done_nxt, conv_nxt;
    logic             ack_nxt, y_nxt;
    logic [EPW-1:0]   ep_nxt, epoch_inc, eff_max;
    logic [AW:0]      err_nxt, err_inc;
    logic             mismatch, last_idx, ep_limit;

    assign wr_data = '{label: wr_label, pat: wr_x};

    // Only the next sample's address is ever needed: idx+1 from NEXT, 0 otherwise
    assign rd_addr = (state == ST_NEXT) ? idx + AW'(1) : '0;

    ox_sample_mem #(
        .NSAMP (NSAMP),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en && !busy),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data_c (rd_data)
    );

    assign mismatch  = (mlp_y != mlp_is_O);
    assign last_idx  = (idx == IDX_LAST);
    assign epoch_inc = (epoch_cnt == '1) ? epoch_cnt : epoch_cnt + EPW'(1);
    assign err_inc   = (err_cnt == '1) ? err_cnt : err_cnt + EW'(1);
    assign eff_max   = (cfg_max_epoch == '0) ? EPW'(1) : cfg_max_epoch;
    assign ep_limit  = (epoch_inc >= eff_max);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_APPLY;
                end else if (inf_req) begin
                    state_nxt = ST_INFER;
                end
            end
            ST_APPLY:     if (cnt == SETTLE_LAST) state_nxt = ST_EVAL;
            ST_EVAL:      state_nxt = mismatch ? ST_LEARN : ST_NEXT;
            ST_LEARN:     state_nxt = ST_HOLD;
            ST_HOLD:      if (cnt == HOLD_LAST) state_nxt = ST_NEXT;
            ST_NEXT:      state_nxt = last_idx ? ST_EPOCH_END : ST_APPLY;
            ST_EPOCH_END: state_nxt = ((err_cnt == '0) || ep_limit) ? ST_DONE : ST_APPLY;
            ST_INFER:     if (cnt == SETTLE_LAST) state_nxt = from_done ? ST_DONE : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // Output and datapath next values
    always_comb begin
        cnt_nxt       = (state_nxt == state) ? cnt + CW'(1) : '0;
        idx_nxt       = idx;
        from_done_nxt = from_done;
        x_nxt         = mlp_x;
        is_o_nxt      = mlp_is_O;
        learn_nxt     = (state_nxt == ST_LEARN);
        busy_nxt      = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
        done_nxt      = (state_nxt == ST_DONE);
        conv_nxt      = converged;
        ep_nxt        = epoch_cnt;
        err_nxt       = err_cnt;
        ack_nxt       = 1'b0;
        y_nxt         = inf_y;
        if (abort) begin
            if (busy) begin
                conv_nxt = 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ep_nxt   = '0;
                        err_nxt  = '0;
                        conv_nxt = 1'b0;
                        idx_nxt  = '0;
                        x_nxt    = rd_data.pat;
                        is_o_nxt = rd_data.label;
                    end else if (inf_req) begin
                        x_nxt         = inf_x;
                        from_done_nxt = (state == ST_DONE);
                    end
                end
                ST_EVAL: begin
                    if (mismatch) begin
                        err_nxt = err_inc;
                    end
                end
                ST_NEXT: begin
                    if (!last_idx) begin
                        idx_nxt  = idx + AW'(1);
                        x_nxt    = rd_data.pat;
                        is_o_nxt = rd_data.label;
                    end
                end
                ST_EPOCH_END: begin
                    ep_nxt = epoch_inc;
                    if (err_cnt == '0) begin
                        conv_nxt = 1'b1;
                    end else if (ep_limit) begin
                        conv_nxt = 1'b0;
                    end else begin
                        err_nxt  = '0;
                        idx_nxt  = '0;
                        x_nxt    = rd_data.pat;
                        is_o_nxt = rd_data.label;
                    end
                end
                ST_INFER: begin
                    if (cnt == SETTLE_LAST) begin
                        ack_nxt = 1'b1;
                        y_nxt   = mlp_y;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            from_done <= 1'b0;
            mlp_x     <= '0;
            mlp_is_O  <= 1'b0;
            mlp_learn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            epoch_cnt <= '0;
            err_cnt   <= '0;
            inf_ack   <= 1'b0;
            inf_y     <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            from_done <= from_done_nxt;
            mlp_x     <= x_nxt;
            mlp_is_O  <= is_o_nxt;
            mlp_learn <= learn_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            converged <= conv_nxt;
            epoch_cnt <= ep_nxt;
            err_cnt   <= err_nxt;
            inf_ack   <= ack_nxt;
            inf_y     <= y_nxt;
        end
    end

endmodule

// File: doc/ox_train_ctrl.md
Name: ox_train_ctrl

Overview:
Training/inference sequencer for the 16-input O/X MLP classifier. Holds a small sample set of 16-bit patterns with O labels. Replays the set epoch by epoch, driving the classifier's x / is_O / learn inputs, and stops on a clean epoch or an epoch limit. Between runs it shares the classifier with a single inference requester via a req/ack handshake. Sits directly above the classifier; its outputs connect 1:1 to the classifier's x, is_O and learn, and it reads back the classifier's y.

Parameters:
NSAMP, 8, number of stored training samples (>=2)
AW, 3, sample address width, clog2(NSAMP)
SETTLE, 3, cycles x/is_O are held before y is sampled (>=1; covers classifier pipeline)
UPD_LAT, 2, cycles x/is_O stay held after the learn pulse (>=1)
EPW, 8, epoch counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin training run (pulse)
abort  in  1  cancel training/inference, return to IDLE
cfg_max_epoch  in  EPW  epoch limit; 0 treated as 1
wr_en  in  1  sample write strobe
wr_addr  in  AW  sample index
wr_x  in  16  sample pattern
wr_label  in  1  1 = pattern is O
inf_req  in  1  inference request (level, held until inf_ack)
inf_x  in  16  pattern to classify
inf_ack  out  1  one-cycle pulse: inf_y valid
inf_y  out  1  classification result, 1 = O
mlp_x  out  16  classifier pattern input
mlp_is_O  out  1  classifier label input
mlp_learn  out  1  classifier learn strobe
mlp_y  in  1  classifier binary output
busy  out  1  high in every state except IDLE/DONE
done  out  1  training finished, high in DONE
converged  out  1  last run ended on a zero-error epoch
epoch_cnt  out  EPW  completed epochs of current/last run
err_cnt  out  AW+1  misclassifications in current/last epoch

Behaviour:
- Reset: state IDLE; all outputs 0; sample memory 0; sample index 0.
- All outputs are registered.
- States: IDLE, APPLY, EVAL, LEARN, HOLD, NEXT, EPOCH_END, DONE, INFER.
- Sample memory writes: accepted only when busy=0. Ignored when busy=1. Index >= NSAMP is ignored.
- IDLE/DONE arbitration: start has priority over inf_req.
  - start: clears epoch_cnt, err_cnt, done, converged; index=0; go to APPLY.
  - Else inf_req: latch inf_x into mlp_x, mlp_learn=0; go to INFER.
  - done stays high in DONE until start, inf_req or abort leaves DONE.
- APPLY: mlp_x/mlp_is_O = sample[index]; wait SETTLE cycles; go to EVAL.
- EVAL (1 cycle): compare mlp_y with label.
  - Mismatch: err_cnt++ (saturating); go to LEARN.
  - Match: go to NEXT.
- LEARN: mlp_learn=1 for exactly one cycle, x/is_O held; go to HOLD.
- HOLD: wait UPD_LAT cycles, x/is_O held; go to NEXT.
- NEXT (1 cycle):
  - index == NSAMP-1: go to EPOCH_END.
  - Otherwise: index++, go to APPLY (no wrap within an epoch).
- EPOCH_END (1 cycle): epoch_cnt++ (saturating).
  - err_cnt == 0: converged=1, done=1, go to DONE.
  - Else if new epoch_cnt >= max(cfg_max_epoch,1): converged=0, done=1, go to DONE.
  - Else: err_cnt=0, index=0, go to APPLY.
- Training latency per sample:
  - Correct sample: SETTLE+2 cycles.
  - Mismatched sample: SETTLE+UPD_LAT+3 cycles.
- INFER: hold latched x for SETTLE cycles. On the next cycle: inf_y=mlp_y, inf_ack=1 for one cycle, return to IDLE (or DONE if entered from DONE). Request-to-ack latency is SETTLE+1 cycles.
- inf_req is never serviced while training; it is held until service.
- abort: highest priority in every busy state; next state is IDLE.
  - mlp_learn is 0 from the next cycle.
  - A learn pulse already registered is not cancelled.
  - No inf_ack is issued for an aborted inference.
  - done=0, converged=0; epoch_cnt/err_cnt hold their values.
- abort in IDLE/DONE: forces IDLE and clears done.
- start or inf_req asserted together with abort: ignored.
- Reset mid-operation: immediate return to reset values; sample memory is cleared.

Decomposition:
- Shared package ox_ctrl_pkg: state encoding, SAMPLE_W=17 ({label, pattern}), default SETTLE/UPD_LAT constants.
- One sub-module, ox_sample_mem: NSAMP x 17 register file with synchronous write, asynchronous-reset clear and combinational read.

Test Plan:
- Stub mlp_y=1, all 8 labels=1, cfg_max_epoch=10, start -> no learn pulses; done and converged=1 after one epoch; epoch_cnt=1, err_cnt=0; run takes 8*(SETTLE+2)+1 = 41 cycles.
- Stub mlp_y=0, labels alternate 1/0, cfg_max_epoch=3 -> 4 learn pulses per epoch, each exactly 1 cycle with x held ±UPD_LAT; done after 3 epochs; converged=0, epoch_cnt=3, err_cnt=4.
- cfg_max_epoch=0, same stimulus -> stops after 1 epoch, epoch_cnt=1.
- In IDLE, inf_req with inf_x=16'hA5A5, stub y=1 -> mlp_x=A5A5, mlp_learn=0; inf_ack pulse 4 cycles after request with inf_y=1. Same cycle start+inf_req -> training starts, inf_ack arrives only after done.
- abort asserted during HOLD of epoch 2 -> IDLE next cycle; busy/done/converged=0; epoch_cnt keeps 1; wr_en during training ignored, accepted after abort (readback via replay).
- rst_n low mid-APPLY -> all outputs 0 asynchronously; a subsequent start with no writes trains on all-zero samples.
